// File: rtl/z16_dmem_arbiter.sv
// Z16 data-memory arbiter: two requesters share one single-port memory.
// One transaction at a time, IDLE -> ACCESS -> ACK, round-robin or fixed priority.
module z16_dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_ack0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_grant,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                sel1;
  logic                in_access;
  logic                in_ack;

  // Winner of an IDLE cycle: contested cycles go to the port that did not win last,
  // or always to port 0 when fixed priority is selected.
  always_comb begin
    sel1 = i_req1;
    if (i_req0 && i_req1) begin
      sel1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end
  end

  // Next-state logic: latch the winner's request in IDLE, capture read data in ACCESS.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          owner_d = sel1;
          we_d    = sel1 ? i_we1 : i_we0;
          addr_d  = sel1 ? i_addr1 : i_addr0;
          wdata_d = sel1 ? i_wdata1 : i_wdata0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        rdata_d = i_mem_rdata;
        last_d  = owner_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; port 0 wins the first contest.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode the current state only, so an ACCESS overlapping reset still writes.
  always_comb begin
    in_access   = (state_q == S_ACCESS);
    in_ack      = (state_q == S_ACK);
    o_busy      = (state_q != S_IDLE);
    o_mem_addr  = in_access ? addr_q : '0;
    o_mem_wen   = in_access & we_q;
    o_mem_wdata = in_access ? wdata_q : '0;
    o_grant     = (in_access || in_ack) ? {owner_q, ~owner_q} : 2'b00;
    o_ack0      = in_ack & ~owner_q;
    o_ack1      = in_ack & owner_q;
    o_rdata0    = (in_ack && !owner_q) ? rdata_q : '0;
    o_rdata1    = (in_ack && owner_q) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// Directed bench for z16_dmem_arbiter: round-robin and fixed-priority instances
// driven by the same requesters, each with its own memory model.
module tb_z16_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;

  logic        ack0_a, ack1_a, mwen_a, busy_a;
  logic [15:0] rdata0_a, rdata1_a, maddr_a, mwdata_a, mrdata_a;
  logic [1:0]  grant_a;
  logic        ack0_b, ack1_b, mwen_b, busy_b;
  logic [15:0] rdata0_b, rdata1_b, maddr_b, mwdata_b, mrdata_b;
  logic [1:0]  grant_b;

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int vectors = 0;
  int miscompares = 0;
  int acks_b = 0;

  always #5 clk = ~clk;

  z16_dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(0)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_ack0(ack0_a), .o_rdata0(rdata0_a),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_ack1(ack1_a), .o_rdata1(rdata1_a),
    .o_mem_addr(maddr_a), .o_mem_wen(mwen_a), .o_mem_wdata(mwdata_a),
    .i_mem_rdata(mrdata_a), .o_grant(grant_a), .o_busy(busy_a)
  );

  z16_dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_ack0(ack0_b), .o_rdata0(rdata0_b),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_ack1(ack1_b), .o_rdata1(rdata1_b),
    .o_mem_addr(maddr_b), .o_mem_wen(mwen_b), .o_mem_wdata(mwdata_b),
    .i_mem_rdata(mrdata_b), .o_grant(grant_b), .o_busy(busy_b)
  );

  // Memory models: combinational read, write on the rising edge, backdoor preload.
  assign mrdata_a = mem_a[maddr_a[7:0]];
  assign mrdata_b = mem_b[maddr_b[7:0]];

  always @(posedge clk) begin
    if (mwen_a) mem_a[maddr_a[7:0]] <= mwdata_a;
    else if (pl_en) mem_a[pl_addr] <= pl_data;
    if (mwen_b) mem_b[maddr_b[7:0]] <= mwdata_b;
    else if (pl_en) mem_b[pl_addr] <= pl_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  initial begin
    int ph, own;
    rst = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0002; wdata0 = 16'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0004; wdata1 = 16'h0;

    // Reset held two cycles with both requests high.
    step();
    step();
    chk("rst busy", busy_a, 0);
    chk("rst grant", grant_a, 0);
    chk("rst ack0", ack0_a, 0);
    chk("rst ack1", ack1_a, 0);
    chk("rst rdata0", rdata0_a, 0);
    chk("rst rdata1", rdata1_a, 0);
    chk("rst mem_addr", maddr_a, 0);
    chk("rst mem_wen", mwen_a, 0);
    chk("rst mem_wdata", mwdata_a, 0);
    chk("rst busy_b", busy_b, 0);

    preload(8'h02, 16'h1111);
    preload(8'h04, 16'h2222);
    preload(8'h10, 16'h1234);

    // Release reset with both ports contending; 4 transactions.
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      ph  = c % 3;
      own = (c / 3) % 2;
      chk($sformatf("rr c%0d grant", c), grant_a,
          (ph == 2) ? 2'b00 : (own == 1 ? 2'b10 : 2'b01));
      chk($sformatf("rr c%0d busy", c), busy_a, (ph != 2));
      chk($sformatf("rr c%0d ack0", c), ack0_a, (ph == 1 && own == 0));
      chk($sformatf("rr c%0d ack1", c), ack1_a, (ph == 1 && own == 1));
      chk($sformatf("rr c%0d rdata0", c), rdata0_a,
          (ph == 1 && own == 0) ? 16'h1111 : 16'h0);
      chk($sformatf("rr c%0d rdata1", c), rdata1_a,
          (ph == 1 && own == 1) ? 16'h2222 : 16'h0);
      chk($sformatf("rr c%0d mem_addr", c), maddr_a,
          (ph == 0) ? (own == 1 ? 16'h4 : 16'h2) : 16'h0);
      chk($sformatf("fp c%0d grant", c), grant_b,
          (ph == 2) ? 2'b00 : 2'b01);
      chk($sformatf("fp c%0d ack1", c), ack1_b, 0);
      chk($sformatf("fp c%0d ack0", c), ack0_b, (ph == 1));
      if (ack0_b) acks_b++;
    end
    chk("fp ack0 count", acks_b, 4);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    chk("drain busy", busy_a, 0);

    // Port 0 write 0x0010 <- 0xBEEF.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
    step();
    chk("wr access wen", mwen_a, 1);
    chk("wr access addr", maddr_a, 16'h0010);
    chk("wr access wdata", mwdata_a, 16'hBEEF);
    chk("wr access ack0", ack0_a, 0);
    step();
    chk("wr ack0", ack0_a, 1);
    chk("wr ack1", ack1_a, 0);
    chk("wr pre-write rdata0", rdata0_a, 16'h1234);
    chk("wr ack wen", mwen_a, 0);
    req0 = 1'b0;
    step();
    chk("wr idle ack0", ack0_a, 0);
    chk("wr idle busy", busy_a, 0);

    // Port 0 read back 0x0010.
    req0 = 1'b1; we0 = 1'b0;
    step();
    chk("rd access wen", mwen_a, 0);
    chk("rd access ack0", ack0_a, 0);
    step();
    chk("rd ack0", ack0_a, 1);
    chk("rd ack1", ack1_a, 0);
    chk("rd rdata0", rdata0_a, 16'hBEEF);
    req0 = 1'b0;
    step();
    chk("rd idle ack0", ack0_a, 0);

    // Late request: port 1 rises during port 0's ACCESS.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0002;
    step();
    chk("late p0 grant", grant_a, 2'b01);
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0004;
    step();
    chk("late p0 ack0", ack0_a, 1);
    chk("late p0 ack1", ack1_a, 0);
    req0 = 1'b0;
    step();
    chk("late idle busy", busy_a, 0);
    chk("late idle grant", grant_a, 2'b00);
    step();
    chk("late p1 grant", grant_a, 2'b10);
    chk("late p1 mem_addr", maddr_a, 16'h0004);
    step();
    chk("late p1 ack1", ack1_a, 1);
    chk("late p1 rdata1", rdata1_a, 16'h2222);
    chk("late p1 rdata0", rdata0_a, 16'h0);
    req1 = 1'b0;
    step();
    chk("late done busy", busy_a, 0);

    // Reset during ACCESS of a port 1 write.
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h5A5A;
    step();
    chk("rstw access grant", grant_a, 2'b10);
    chk("rstw access wen", mwen_a, 1);
    rst = 1'b1;
    step();
    chk("rstw busy", busy_a, 0);
    chk("rstw ack1", ack1_a, 0);
    chk("rstw grant", grant_a, 2'b00);
    chk("rstw mem commit", mem_a[8'h20], 16'h5A5A);
    rst = 1'b0;
    req1 = 1'b0;
    step();
    chk("rstw after ack1", ack1_a, 0);
    chk("rstw after busy", busy_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
